// File: rtl/pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : pwm_compare
// Description : PWM comparator with a duty handshake. A new duty value is held
//               pending and applied only at a counter wrap (period boundary).
//               Optional macro PWM_COMPARE_IRQ_EN adds a wrap interrupt
//               (irq_clr input, irq output).
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_compare #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] cnt,
  input  logic [width-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm,
  output logic             period_tick
`ifdef PWM_COMPARE_IRQ_EN
  ,
  input  logic             irq_clr,
  output logic             irq
`endif
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [width-1:0] cnt_max = '1;

  state_t           state;
  state_t           state_next;
  logic [width-1:0] pend_duty;
  logic [width-1:0] active_duty;
  logic             wrap;
  logic             handshake;

  // Next-state logic and ready output; ready is forced low while in reset.
  always_comb begin
    state_next = state;
    duty_ready = 1'b0;
    handshake  = 1'b0;
    wrap       = en && (cnt == cnt_max);
    case (state)
      IDLE: begin
        duty_ready = !rst;
        handshake  = duty_valid && !rst;
        if (handshake) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (wrap) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A handshake that coincides with a wrap only captures; the apply happens
  // at the next wrap because the state is still IDLE on this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_duty   <= '0;
      active_duty <= '0;
      pwm         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      if (handshake) begin
        pend_duty <= duty_in;
      end
      if ((state == PENDING) && wrap) begin
        active_duty <= pend_duty;
      end
      pwm         <= (cnt < active_duty);
      period_tick <= wrap;
    end
  end

`ifdef PWM_COMPARE_IRQ_EN
  // Set takes priority over clear so a wrap is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (wrap) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_compare.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_compare
// Description : Self-checking bench for pwm_compare (width=8) against a
//               queue-based reference model; directed scenarios plus random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_compare;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] cnt;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm;
  logic       period_tick;
  logic       irq_clr;
`ifdef PWM_COMPARE_IRQ_EN
  logic       irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: at most one queued duty, the applied duty, irq flag.
  int active_m = 0;
  int pend_q[$];
  bit irq_m = 1'b0;

  always #5 clk = ~clk;

  pwm_compare #(.width(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cnt        (cnt),
    .duty_in    (duty_in),
    .duty_valid (duty_valid),
    .duty_ready (duty_ready),
    .pwm        (pwm),
    .period_tick(period_tick)
`ifdef PWM_COMPARE_IRQ_EN
    ,
    .irq_clr    (irq_clr),
    .irq        (irq)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // One clock cycle with the inputs currently applied; the counter advances
  // like the upstream counter afterwards.
  task automatic tick();
    bit exp_pwm;
    bit exp_tick;
    bit wrap;
    #1;
    check_eq("duty_ready", duty_ready, (!rst && pend_q.size() == 0) ? 1 : 0);
    wrap     = en && (cnt == 8'd255);
    exp_pwm  = (int'(cnt) < active_m);
    exp_tick = wrap;
    if (rst) begin
      pend_q.delete();
      active_m = 0;
      exp_pwm  = 1'b0;
      exp_tick = 1'b0;
      irq_m    = 1'b0;
    end else begin
      if (pend_q.size() != 0) begin
        if (wrap) active_m = pend_q.pop_front();
      end else if (duty_valid) begin
        pend_q.push_back(int'(duty_in));
      end
      if (wrap) irq_m = 1'b1;
      else if (irq_clr) irq_m = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("pwm", pwm, exp_pwm);
    check_eq("period_tick", period_tick, exp_tick);
`ifdef PWM_COMPARE_IRQ_EN
    check_eq("irq", irq, irq_m);
`endif
    if (en) cnt = cnt + 8'd1;
  endtask

  // Handshake a duty at cnt==0 and run up to and including the wrap.
  task automatic load_duty(input logic [7:0] v);
    duty_valid = 1'b1;
    duty_in    = v;
    tick();
    duty_valid = 1'b0;
    repeat (255) tick();
  endtask

  // Run one full period (cnt 0..255) and count cycles with pwm high.
  task automatic run_period(output int highs);
    highs = 0;
    repeat (256) begin
      tick();
      if (pwm === 1'b1) highs++;
    end
  endtask

  initial begin
    int highs;
    rst        = 1'b1;
    en         = 1'b0;
    cnt        = 8'd0;
    duty_in    = 8'd0;
    duty_valid = 1'b1;
    irq_clr    = 1'b0;
    repeat (3) tick();
    rst        = 1'b0;
    duty_valid = 1'b0;
    en         = 1'b1;
    cnt        = 8'd0;

    // Duty 64: not applied in the first period, 64 highs in the second.
    duty_valid = 1'b1;
    duty_in    = 8'd64;
    tick();
    duty_valid = 1'b0;
    highs = 0;
    repeat (255) begin
      tick();
      if (pwm === 1'b1) highs++;
    end
    check_eq("first_period_highs", highs, 0);
    run_period(highs);
    check_eq("duty64_highs", highs, 64);

    // Held valid with 10 then 20: only 10 is captured.
    duty_valid = 1'b1;
    duty_in    = 8'd10;
    tick();
    duty_in    = 8'd20;
    repeat (10) tick();
    duty_valid = 1'b0;
    repeat (245) tick();
    run_period(highs);
    check_eq("duty10_highs", highs, 10);

    // Handshake coinciding with wrap: 128 waits for the next wrap.
    cnt        = 8'd255;
    duty_valid = 1'b1;
    duty_in    = 8'd128;
    tick();
    duty_valid = 1'b0;
    run_period(highs);
    check_eq("wrap_hs_not_applied", highs, 10);
    run_period(highs);
    check_eq("duty128_highs", highs, 128);

    // Boundary duties 0 and 255.
    load_duty(8'd0);
    run_period(highs);
    check_eq("duty0_highs", highs, 0);
    load_duty(8'd255);
    run_period(highs);
    check_eq("duty255_highs", highs, 255);

    // Enable toggling, including a frozen cnt=255.
    cnt = 8'd250;
    repeat (600) begin
      en = ($urandom % 2) != 0;
      tick();
    end
    en  = 1'b0;
    cnt = 8'd255;
    repeat (4) tick();
    en = 1'b1;

    // Reset while pending 50.
    cnt        = 8'd0;
    duty_valid = 1'b1;
    duty_in    = 8'd50;
    tick();
    duty_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    cnt = 8'd0;
    run_period(highs);
    run_period(highs);
    check_eq("after_reset_highs", highs, 0);

    // Interrupt clear coinciding with wrap, then plain clear.
    cnt     = 8'd254;
    tick();
    irq_clr = 1'b1;
    tick();
    tick();
    irq_clr = 1'b0;
    tick();

    // Random traffic.
    repeat (3000) begin
      en         = ($urandom % 4) != 0;
      duty_valid = ($urandom % 3) == 0;
      case ($urandom % 4)
        0: duty_in = 8'd0;
        1: duty_in = 8'd255;
        default: duty_in = 8'($urandom);
      endcase
      irq_clr = ($urandom % 8) == 0;
      rst     = ($urandom % 200) == 0;
      if (($urandom % 50) == 0) cnt = 8'd255;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_compare.md
PWM_COMPARE -- requirements
Module: pwm_compare

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the bit width of the count input and of the duty values.
REQ-002 Port clk SHALL be an input, 1 bit wide: the rising-edge clock shared with the upstream counter.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, synchronous, active-high.
REQ-004 Port en SHALL be an input, 1 bit wide: the same enable that advances the upstream counter.
REQ-005 Port cnt SHALL be an input, width bits wide, unsigned: the current upstream counter value.
REQ-006 Port duty_in SHALL be an input, width bits wide, unsigned: the requested duty value.
REQ-007 Port duty_valid SHALL be an input, 1 bit wide: duty_in is valid.
REQ-008 Port duty_ready SHALL be an output, 1 bit wide: the block can accept duty_in.
REQ-009 Port pwm SHALL be an output, 1 bit wide, registered: the PWM waveform.
REQ-010 Port period_tick SHALL be an output, 1 bit wide, registered: one-cycle pulse per counter period.

Function
REQ-011 A wrap event SHALL be en==1 and cnt==2^width-1 in the same cycle.
REQ-012 The block SHALL contain two states: IDLE (no pending duty) and PENDING (duty captured, waiting for wrap).
REQ-013 duty_ready SHALL be 1 in IDLE and 0 in PENDING, and SHALL be 0 in any cycle with rst==1.
REQ-014 A handshake SHALL occur when duty_valid==1 and duty_ready==1 at a clk edge: duty_in is captured into pend_duty and the state moves IDLE->PENDING.
REQ-015 On a wrap event in PENDING, active_duty SHALL load pend_duty and the state SHALL move PENDING->IDLE.
REQ-016 A handshake coinciding with a wrap event in IDLE SHALL capture the value into PENDING, and that value SHALL NOT be applied until the following wrap event.
REQ-017 duty_valid while in PENDING SHALL be ignored; the pending value is never overwritten.
REQ-018 pwm SHALL be updated every cycle to (cnt < active_duty), unsigned width-bit compare, with 1-cycle latency from cnt.
REQ-019 active_duty==0 SHALL give pwm constantly 0, and active_duty==2^width-1 SHALL give pwm 0 only when cnt==2^width-1.
REQ-020 period_tick SHALL be 1 exactly one cycle after each wrap event, and 0 otherwise.
REQ-021 When en==0, pwm SHALL hold the compare of the frozen cnt, and no wrap event SHALL occur.
REQ-022 Duty changes SHALL take effect only at period boundaries; no partial-period glitch is permitted.

Reset
REQ-023 On clk edge with rst==1: state=IDLE, active_duty=0, pend_duty=0, pwm=0, period_tick=0.
REQ-024 Reset mid-PENDING SHALL discard the pending duty, and the cycle after rst deasserts SHALL show duty_ready==1.
REQ-025 rst SHALL take priority over handshake and wrap events in the same cycle.

Configuration
REQ-026 Macro PWM_COMPARE_IRQ_EN SHALL, when defined, add input irq_clr (1 bit) and registered output irq (1 bit), reset to 0.
REQ-027 With PWM_COMPARE_IRQ_EN defined, irq SHALL set on each wrap event and clear on irq_clr==1, with set winning when both occur in the same cycle.
REQ-028 Without PWM_COMPARE_IRQ_EN, the ports irq_clr and irq and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (width=8)
REQ-029 The bench SHALL apply reset, handshake duty 64, and run en=1 from cnt=0 for 2 periods -> duty applied only after first wrap; second period pwm=1 for exactly 64 cycles; period_tick pulses after each wrap.
REQ-030 The bench SHALL apply duty_valid held with 10 then 20 while PENDING -> only 10 captured; duty_ready=0 until wrap; then 10 applied.
REQ-031 The bench SHALL apply handshake duty 128 in the same cycle as cnt=255,en=1 -> value stays pending; applied at the next wrap, not this one.
REQ-032 The bench SHALL apply duty 0 and then 255 -> pwm never 1 over a full period; then pwm 0 only in the cycle after cnt=255.
REQ-033 The bench SHALL apply en toggling 0/1 -> pwm tracks the frozen cnt; no period_tick while en=0 at cnt=255.
REQ-034 The bench SHALL assert rst while PENDING with duty 50 -> pending discarded; active_duty=0; pwm=0; duty_ready=1 one cycle after rst deasserts. With PWM_COMPARE_IRQ_EN, irq sets on wrap, clears on irq_clr, and stays 1 if irq_clr coincides with a wrap.
